// File: rtl/fdc_cmd_phase_ctrl_if.sv
// Host data-register and execution-engine signals of the FDC command/result sequencer.
// slave = sequencer side, master = CPU/engine side.
interface fdc_cmd_phase_ctrl_if #(
  parameter int MAX_CMD = 9,
  parameter int MAX_RES = 7
);
  logic                   host_wr;
  logic [7:0]             host_wr_data;
  logic                   host_rd;
  logic [7:0]             host_rd_data;
  logic                   rqm;
  logic                   dio;
  logic                   busy;
  logic                   int_req;
  logic                   exec_start;
  logic                   exec_abort;
  logic [4:0]             exec_opcode;
  logic [8*MAX_CMD-1:0]   exec_params;
  logic                   exec_done;
  logic                   exec_int;
  logic [2:0]             exec_res_len;
  logic [8*MAX_RES-1:0]   exec_result;

  modport slave (
    input  host_wr, host_wr_data, host_rd,
    input  exec_done, exec_int, exec_res_len, exec_result,
    output host_rd_data, rqm, dio, busy, int_req,
    output exec_start, exec_abort, exec_opcode, exec_params
  );

  modport master (
    output host_wr, host_wr_data, host_rd,
    output exec_done, exec_int, exec_res_len, exec_result,
    input  host_rd_data, rqm, dio, busy, int_req,
    input  exec_start, exec_abort, exec_opcode, exec_params
  );
endinterface

// File: rtl/fdc_cmd_phase_ctrl.sv
// 82077AA command/result phase sequencer: collects command bytes, launches the execution
// engine, returns result bytes and drives MSR RQM/DIO/BUSY plus the interrupt request.
module fdc_cmd_phase_ctrl #(
  parameter int MAX_CMD = 9,
  parameter int MAX_RES = 7,
  parameter int RQM_GAP = 2
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 sw_reset,
  fdc_cmd_phase_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_CMD + 1);
  localparam int RES_W = $clog2(MAX_RES);
  localparam int GAP_W = $clog2(RQM_GAP + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        len_q, len_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [MAX_CMD-1:0][7:0] params_q, params_d;
  logic [MAX_RES-1:0][7:0] res_q, res_d;
  logic [2:0]              res_len_q, res_len_d;
  logic [4:0]              opcode_q, opcode_d;
  logic                    rqm_q, rqm_d;
  logic                    dio_q, dio_d;
  logic                    busy_q, busy_d;
  logic                    start_q, start_d;
  logic                    abort_q, abort_d;
  logic                    int_q, int_d;

  logic                    wr_acc_s;
  logic                    rd_acc_s;
  logic                    done_acc_s;
  logic [IDX_W-1:0]        idx_inc_s;
  logic [3:0]              op_len_s;
  logic [2:0]              done_len_s;
  logic [RES_W-1:0]        res_sel_s;

  // Command length in bytes including the opcode; 0 marks an invalid opcode.
  function automatic logic [3:0] cmd_len(input logic [4:0] op);
    case (op)
      5'h02, 5'h05, 5'h06, 5'h09, 5'h0C: cmd_len = 4'd9;
      5'h0D:                             cmd_len = 4'd6;
      5'h03, 5'h0F:                      cmd_len = 4'd3;
      5'h04, 5'h07, 5'h0A:               cmd_len = 4'd2;
      5'h08, 5'h10:                      cmd_len = 4'd1;
      default:                           cmd_len = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    if (int'(len) > MAX_RES) begin
      clamp_len = 3'(MAX_RES);
    end else begin
      clamp_len = len;
    end
  endfunction

  // Host strobes only count while RQM is presented; exec_done is blind in the launch cycle.
  assign wr_acc_s   = bus.host_wr & rqm_q & ((state_q == ST_IDLE) | (state_q == ST_CMD));
  assign rd_acc_s   = bus.host_rd & rqm_q & (state_q == ST_RESULT);
  assign done_acc_s = bus.exec_done & ~start_q & (state_q == ST_EXEC);
  assign idx_inc_s  = idx_q + IDX_W'(1);
  assign op_len_s   = cmd_len(bus.host_wr_data[4:0]);
  assign done_len_s = clamp_len(bus.exec_res_len);
  assign res_sel_s  = idx_q[RES_W-1:0];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    gap_d     = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
    params_d  = params_q;
    res_d     = res_q;
    res_len_d = res_len_q;
    opcode_d  = opcode_q;
    int_d     = int_q;
    abort_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_acc_s) begin
          gap_d = GAP_W'(RQM_GAP);
          if (bus.host_wr_data[4:0] == 5'h08) begin
            int_d = 1'b0;
          end else begin
            int_d = int_q;
          end
          if (op_len_s == 4'd0) begin
            res_d     = '0;
            res_d[0]  = 8'h80;
            res_len_d = 3'd1;
            idx_d     = '0;
            state_d   = ST_RESULT;
          end else begin
            params_d    = '0;
            params_d[0] = bus.host_wr_data;
            opcode_d    = bus.host_wr_data[4:0];
            len_d       = IDX_W'(op_len_s);
            idx_d       = IDX_W'(1);
            state_d     = (op_len_s == 4'd1) ? ST_EXEC : ST_CMD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (wr_acc_s) begin
          gap_d           = GAP_W'(RQM_GAP);
          params_d[idx_q] = bus.host_wr_data;
          idx_d           = idx_inc_s;
          state_d         = (idx_inc_s == len_q) ? ST_EXEC : ST_CMD;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_EXEC: begin
        if (done_acc_s) begin
          res_d     = bus.exec_result;
          res_len_d = done_len_s;
          idx_d     = '0;
          int_d     = int_q | bus.exec_int;
          state_d   = (done_len_s == 3'd0) ? ST_IDLE : ST_RESULT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_RESULT: begin
        if (rd_acc_s) begin
          gap_d = GAP_W'(RQM_GAP);
          int_d = 1'b0;
          if (idx_inc_s == IDX_W'(res_len_q)) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_inc_s;
            state_d = ST_RESULT;
          end
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Software reset behaves like reset but keeps the last command parameters.
    if (sw_reset) begin
      abort_d   = (state_q == ST_EXEC);
      state_d   = ST_IDLE;
      idx_d     = '0;
      len_d     = '0;
      gap_d     = '0;
      res_d     = '0;
      res_len_d = 3'd0;
      opcode_d  = 5'd0;
      int_d     = 1'b0;
      params_d  = params_q;
    end else begin
      abort_d = 1'b0;
    end

    start_d = ~sw_reset & (state_d == ST_EXEC) & (state_q != ST_EXEC);
    rqm_d   = ~sw_reset & (state_d != ST_EXEC) & (gap_d == '0);
    dio_d   = (state_d == ST_RESULT);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      params_q  <= '0;
      res_q     <= '0;
      res_len_q <= 3'd0;
      opcode_q  <= 5'd0;
      rqm_q     <= 1'b1;
      dio_q     <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      params_q  <= params_d;
      res_q     <= res_d;
      res_len_q <= res_len_d;
      opcode_q  <= opcode_d;
      rqm_q     <= rqm_d;
      dio_q     <= dio_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      int_q     <= int_d;
    end
  end

  assign bus.host_rd_data = (state_q == ST_RESULT) ? res_q[res_sel_s] : 8'hFF;
  assign bus.rqm          = rqm_q;
  assign bus.dio          = dio_q;
  assign bus.busy         = busy_q;
  assign bus.int_req      = int_q;
  assign bus.exec_start   = start_q;
  assign bus.exec_abort   = abort_q;
  assign bus.exec_opcode  = opcode_q;
  assign bus.exec_params  = params_q;
endmodule

// File: tb/tb_fdc_cmd_phase_ctrl.sv
// Directed bench for the FDC command/result sequencer with a queue-based behavioural
// model checked every cycle, plus literal expectations for the documented scenarios.
module tb_fdc_cmd_phase_ctrl;
  localparam int MAX_CMD = 9;
  localparam int MAX_RES = 7;
  localparam int RQM_GAP = 2;
  localparam int P_IDLE = 0;
  localparam int P_CMD  = 1;
  localparam int P_EXEC = 2;
  localparam int P_RES  = 3;

  logic clk = 1'b0;
  logic reset;
  logic sw_reset;
  int   total = 0;
  int   bad = 0;
  int   start_cnt = 0;
  int   abort_cnt = 0;

  fdc_cmd_phase_ctrl_if #(.MAX_CMD(MAX_CMD), .MAX_RES(MAX_RES)) bus ();

  fdc_cmd_phase_ctrl #(.MAX_CMD(MAX_CMD), .MAX_RES(MAX_RES), .RQM_GAP(RQM_GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_reset (sw_reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int                   m_phase;
  int                   m_gap;
  int                   m_need;
  bit                   m_int;
  bit                   m_start;
  bit                   m_abort;
  bit                   m_swr;
  logic [4:0]           m_opc;
  logic [8*MAX_CMD-1:0] m_params;
  byte unsigned         m_cmd[$];
  byte unsigned         m_res[$];

  function automatic int len_of(input logic [4:0] op);
    case (op)
      5'h02, 5'h05, 5'h06, 5'h09, 5'h0C: return 9;
      5'h0D:                             return 6;
      5'h03, 5'h0F:                      return 3;
      5'h04, 5'h07, 5'h0A:               return 2;
      5'h08, 5'h10:                      return 1;
      default:                           return 0;
    endcase
  endfunction

  function automatic bit m_rqm();
    return !m_swr && (m_phase != P_EXEC) && (m_gap == 0);
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit rq, ld, st, ab;
    int n;
    rq = m_rqm();
    ld = 1'b0;
    st = 1'b0;
    ab = 1'b0;
    if (reset) begin
      m_phase = P_IDLE; m_gap = 0; m_int = 1'b0; m_opc = 5'd0; m_params = '0;
      m_cmd.delete(); m_res.delete(); m_need = 0;
    end else if (sw_reset) begin
      ab = (m_phase == P_EXEC);
      m_phase = P_IDLE; m_gap = 0; m_int = 1'b0; m_opc = 5'd0;
      m_cmd.delete(); m_res.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (bus.host_wr && rq) begin
          ld = 1'b1;
          if (bus.host_wr_data[4:0] == 5'h08) m_int = 1'b0;
          m_need = len_of(bus.host_wr_data[4:0]);
          if (m_need == 0) begin
            m_res = '{8'h80};
            m_phase = P_RES;
          end else begin
            m_cmd = '{bus.host_wr_data};
            m_opc = bus.host_wr_data[4:0];
            m_phase = P_CMD;
          end
        end
        P_CMD: if (bus.host_wr && rq) begin
          ld = 1'b1;
          m_cmd.push_back(bus.host_wr_data);
        end
        P_EXEC: if (bus.exec_done && !m_start) begin
          n = (int'(bus.exec_res_len) > MAX_RES) ? MAX_RES : int'(bus.exec_res_len);
          m_res.delete();
          for (int i = 0; i < n; i++) m_res.push_back(bus.exec_result[8*i +: 8]);
          if (bus.exec_int) m_int = 1'b1;
          m_phase = (n == 0) ? P_IDLE : P_RES;
        end
        P_RES: if (bus.host_rd && rq) begin
          ld = 1'b1;
          m_int = 1'b0;
          void'(m_res.pop_front());
          if (m_res.size() == 0) m_phase = P_IDLE;
        end
        default: ;
      endcase
      if (m_phase == P_CMD && m_cmd.size() == m_need) begin
        m_phase = P_EXEC;
        st = 1'b1;
        m_params = '0;
        foreach (m_cmd[i]) m_params[8*i +: 8] = m_cmd[i];
      end
      if (ld) m_gap = RQM_GAP;
      else if (m_gap > 0) m_gap--;
    end
    m_swr   = reset ? 1'b0 : sw_reset;
    m_start = st;
    m_abort = ab;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("rqm", bus.rqm, m_rqm());
      chk("dio", bus.dio, m_phase == P_RES);
      chk("busy", bus.busy, m_phase != P_IDLE);
      chk("int_req", bus.int_req, m_int);
      chk("host_rd_data", bus.host_rd_data, (m_phase == P_RES) ? m_res[0] : 8'hFF);
      chk("exec_start", bus.exec_start, m_start);
      chk("exec_abort", bus.exec_abort, m_abort);
      chk("exec_opcode", bus.exec_opcode, m_opc);
      if (m_phase == P_EXEC) chk("exec_params", bus.exec_params, m_params);
    end
  end

  always @(negedge clk) begin
    if (bus.exec_start === 1'b1) start_cnt++;
    if (bus.exec_abort === 1'b1) abort_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rqm(input string nm);
    int n = 0;
    while (bus.rqm !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.rqm !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: rqm wait timed out, got %b expected 1", nm, bus.rqm);
    end
  endtask

  task automatic strobe_wr(input logic [7:0] b);
    bus.host_wr = 1'b1;
    bus.host_wr_data = b;
    tick();
    bus.host_wr = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wait_rqm("wr_rqm");
    strobe_wr(b);
  endtask

  task automatic rd_byte(input logic [7:0] exp, input bit both, input string nm);
    wait_rqm("rd_rqm");
    chk(nm, bus.host_rd_data, exp);
    bus.host_rd = 1'b1;
    if (both) begin
      bus.host_wr = 1'b1;
      bus.host_wr_data = 8'h02;
    end
    tick();
    bus.host_rd = 1'b0;
    bus.host_wr = 1'b0;
  endtask

  task automatic finish_exec(input logic [2:0] len, input bit irq, input logic [55:0] res);
    bus.exec_done = 1'b1;
    bus.exec_res_len = len;
    bus.exec_int = irq;
    bus.exec_result = res;
    tick();
    bus.exec_done = 1'b0;
    bus.exec_int = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw_reset = 1'b0;
    bus.host_wr = 1'b0;
    bus.host_wr_data = 8'h00;
    bus.host_rd = 1'b0;
    bus.exec_done = 1'b0;
    bus.exec_int = 1'b0;
    bus.exec_res_len = 3'd0;
    bus.exec_result = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_rqm", bus.rqm, 1'b1);
    chk("rst_dio", bus.dio, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_int", bus.int_req, 1'b0);
    chk("rst_rd_data", bus.host_rd_data, 8'hFF);
    chk("rst_params", bus.exec_params, 72'h0);

    // SPECIFY with a write inside the RQM gap and one during EXEC
    wr_byte(8'h03);
    strobe_wr(8'hAA);
    wr_byte(8'hDF);
    wr_byte(8'h02);
    chk("spec_start", bus.exec_start, 1'b1);
    chk("spec_params", bus.exec_params[23:0], 24'h02DF03);
    chk("spec_busy", bus.busy, 1'b1);
    strobe_wr(8'h55);
    finish_exec(3'd0, 1'b0, 56'h0);
    chk("spec_idle_busy", bus.busy, 1'b0);
    chk("spec_no_int", bus.int_req, 1'b0);
    chk("spec_start_cnt", start_cnt, 1);

    // READ DATA (MFM): 0x46 plus eight parameters
    wr_byte(8'h46);
    for (int i = 1; i <= 8; i++) wr_byte(8'(i));
    chk("rd_start", bus.exec_start, 1'b1);
    chk("rd_opcode", bus.exec_opcode, 5'h06);
    chk("rd_param0", bus.exec_params[7:0], 8'h46);
    chk("rd_param8", bus.exec_params[71:64], 8'h08);
    finish_exec(3'd7, 1'b1, 56'hFFFFFFFFFFFFFF);
    chk("launch_done_ignored", bus.dio, 1'b0);
    bus.host_rd = 1'b1;
    tick();
    bus.host_rd = 1'b0;
    finish_exec(3'd7, 1'b1, 56'hA6A5A4A3A2A1A0);
    chk("rd_int_set", bus.int_req, 1'b1);
    chk("rd_dio", bus.dio, 1'b1);
    for (int i = 0; i < 7; i++) begin
      rd_byte(8'hA0 + 8'(i), (i == 2), "rd_result");
      if (i == 0) chk("int_clr_on_read", bus.int_req, 1'b0);
    end
    chk("rd_end_busy", bus.busy, 1'b0);
    chk("rd_end_data", bus.host_rd_data, 8'hFF);

    // Invalid opcode returns a single 0x80 status byte
    wr_byte(8'h1F);
    chk("inv_dio", bus.dio, 1'b1);
    chk("inv_byte", bus.host_rd_data, 8'h80);
    rd_byte(8'h80, 1'b0, "inv_read");
    chk("inv_idle", bus.busy, 1'b0);
    chk("inv_no_start", start_cnt, 2);

    // exec_done while idle must be ignored
    finish_exec(3'd3, 1'b1, 56'h123456);
    chk("idle_done_int", bus.int_req, 1'b0);
    chk("idle_done_dio", bus.dio, 1'b0);

    // RECALIBRATE with interrupt, SENSE INT clears it, then abort via sw_reset
    wr_byte(8'h07);
    wr_byte(8'h00);
    tick();
    finish_exec(3'd0, 1'b1, 56'h0);
    chk("recal_int", bus.int_req, 1'b1);
    chk("recal_idle", bus.busy, 1'b0);
    wr_byte(8'h08);
    chk("sense_int_clr", bus.int_req, 1'b0);
    chk("sense_start", bus.exec_start, 1'b1);
    tick();
    sw_reset = 1'b1;
    tick();
    chk("abort_pulse", bus.exec_abort, 1'b1);
    chk("swr_busy", bus.busy, 1'b0);
    tick();
    tick();
    chk("swr_rqm_low", bus.rqm, 1'b0);
    chk("abort_once", bus.exec_abort, 1'b0);
    sw_reset = 1'b0;
    tick();
    chk("swr_rqm_back", bus.rqm, 1'b1);
    chk("swr_params_kept", bus.exec_params[7:0], 8'h08);
    finish_exec(3'd2, 1'b1, 56'hBEEF);
    chk("stale_done_busy", bus.busy, 1'b0);
    chk("stale_done_int", bus.int_req, 1'b0);
    chk("abort_cnt", abort_cnt, 1);
    chk("start_cnt", start_cnt, 4);

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
